// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// With SERIAL_ADDER_SUB_EN defined the bundle also carries the sub mode select.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;

   modport master (output start, a, b, sub, input busy, done, sum, c_out);
   modport slave  (input start, a, b, sub, output busy, done, sum, c_out);
`else
   modport master (output start, a, b, input busy, done, sum, c_out);
   modport slave  (input start, a, b, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add cell plus a carry flop, LSB first, under an IDLE/RUN/DONE FSM.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub input selecting a-b (c_out then means "no borrow").
module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q,  carry_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             c_out_q,  c_out_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic             bit_s;
   logic             carry_nx_s;
   logic [WIDTH-1:0] sum_nx_s;
   logic             last_s;

   // Full-add cell and the sum shift register's next value (new bit enters at the MSB).
   always_comb begin
      bit_s      = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
      carry_nx_s = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
      sum_nx_s   = (sum_sh_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
      last_s     = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      c_out_d  = c_out_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_sh_d   = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
               // Subtraction is a + ~b + 1, so the inverted operand and the +1 enter here.
               b_sh_d   = bus.sub ? ~bus.b : bus.b;
               carry_d  = bus.sub;
`else
               b_sh_d   = bus.b;
               carry_d  = 1'b0;
`endif
               sum_sh_d = {WIDTH{1'b0}};
               cnt_d    = {CNT_W{1'b0}};
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = sum_nx_s;
            carry_d  = carry_nx_s;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_s) begin
               sum_d   = sum_nx_s;
               c_out_d = carry_nx_s;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               busy_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset also aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= {WIDTH{1'b0}};
         b_sh_q   <= {WIDTH{1'b0}};
         sum_sh_q <= {WIDTH{1'b0}};
         carry_q  <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         sum_q    <= {WIDTH{1'b0}};
         c_out_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         c_out_q  <= c_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus random operands against an arithmetic model.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder;

   localparam int W = 8;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic; result is {carry/not-borrow, W-bit value}.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int unsigned xi;
      int unsigned yi;
      int unsigned r;
      xi = int'(x);
      yi = int'(y);
      if (s) begin
         r = (xi + (1 << W) - yi) % (1 << W);
         return {(xi >= yi), W'(r)};
      end else begin
         r = xi + yi;
         return {(r >= (1 << W)), W'(r % (1 << W))};
      end
   endfunction

   // Issue one operation and wait (bounded) for its done pulse; lat = edges after the start edge.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [W-1:0] osum, output logic oc, output int lat, output int busy_n);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ia;
      bus.b     = ib;
      lat       = -1;
      busy_n    = 0;
      osum      = '0;
      oc        = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
         end
         if (bus.busy) busy_n++;
         if (bus.done) begin
            lat  = i;
            osum = bus.sum;
            oc   = bus.c_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({bus.busy, bus.done, bus.c_out, bus.sum} !== {3'b000, {W{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b c_out=%b sum=%0d, required all zero",
                  bus.busy, bus.done, bus.c_out, bus.sum);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] s;
      logic c;
      int lat, bn;
      do_op(W'(3), W'(5), s, c, lat, bn);
      n_tests++;
      if (lat !== W) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d edges, required %0d", lat, W);
      end
      n_tests++;
      if (bn !== W) begin
         n_fail++;
         $display("FAIL basic_busy_len: got %0d cycles, required %0d", bn, W);
      end
      n_tests++;
      if ({c, s} !== {1'b0, W'(8)}) begin
         n_fail++;
         $display("FAIL basic_sum: got c=%b sum=%0d, required c=0 sum=8", c, s);
      end
      @(negedge clk);
      n_tests++;
      if (bus.done !== 1'b0 || bus.sum !== W'(8)) begin
         n_fail++;
         $display("FAIL basic_done_pulse: done=%b sum=%0d, required done=0 sum=8", bus.done, bus.sum);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] s;
      logic c;
      int lat, bn;
      do_op(W'(255), W'(1), s, c, lat, bn);
      n_tests++;
      if ({c, s} !== {1'b1, W'(0)}) begin
         n_fail++;
         $display("FAIL wrap_255_1: got c=%b sum=%0d, required c=1 sum=0", c, s);
      end
      do_op(W'(200), W'(100), s, c, lat, bn);
      n_tests++;
      if ({c, s} !== {1'b1, W'(44)}) begin
         n_fail++;
         $display("FAIL wrap_200_100: got c=%b sum=%0d, required c=1 sum=44", c, s);
      end
   endtask

   task automatic test_start_ignored();
      int dones;
      int first;
      logic [W-1:0] s;
      logic c;
      dones = 0;
      first = -1;
      s     = '0;
      c     = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = W'(10);
      bus.b     = W'(20);
      @(posedge clk);
      for (int i = 0; i < 3 * W + 6; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         if (i == 3) begin
            bus.start = 1'b1;
            bus.a     = W'(1);
            bus.b     = W'(1);
         end
         if (i == 4) bus.start = 1'b0;
         if (bus.done) begin
            dones++;
            if (first < 0) begin
               first = i;
               s     = bus.sum;
               c     = bus.c_out;
            end
         end
      end
      n_tests++;
      if (first !== W || {c, s} !== {1'b0, W'(30)}) begin
         n_fail++;
         $display("FAIL start_ignored_result: at=%0d c=%b sum=%0d, required at=%0d c=0 sum=30",
                  first, c, s, W);
      end
      n_tests++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL start_ignored_pulses: got %0d done pulses, required 1", dones);
      end
   endtask

   task automatic test_reset_mid_op();
      int dones;
      logic [W-1:0] s;
      logic c;
      int lat, bn;
      dones = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = W'(100);
      bus.b     = W'(27);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         if (bus.done) dones++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({bus.busy, bus.done, bus.c_out, bus.sum} !== {3'b000, {W{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_mid_op_state: busy=%b done=%b c_out=%b sum=%0d, required all zero",
                  bus.busy, bus.done, bus.c_out, bus.sum);
      end
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      n_tests++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_op_no_done: got %0d done pulses, required 0", dones);
      end
      do_op(W'(7), W'(9), s, c, lat, bn);
      n_tests++;
      if ({c, s} !== {1'b0, W'(16)} || lat !== W) begin
         n_fail++;
         $display("FAIL after_reset_op: c=%b sum=%0d lat=%0d, required c=0 sum=16 lat=%0d", c, s, lat, W);
      end
   endtask

   task automatic test_back_to_back();
      int d_at [2];
      logic [W-1:0] s [2];
      logic c [2];
      int nd;
      nd = 0;
      d_at[0] = -1;
      d_at[1] = -1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = W'(8'h0F);
      bus.b     = W'(8'h01);
      @(posedge clk);
      for (int i = 0; i < 3 * W + 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.a = W'(8'h80);
            bus.b = W'(8'h80);
         end
         if (bus.done) begin
            if (nd < 2) begin
               d_at[nd] = i;
               s[nd]    = bus.sum;
               c[nd]    = bus.c_out;
            end
            nd++;
            if (nd == 2) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      n_tests++;
      if (nd !== 2) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d done pulses, required 2", nd);
      end
      n_tests++;
      if (d_at[0] !== W || {c[0], s[0]} !== {1'b0, W'(8'h10)}) begin
         n_fail++;
         $display("FAIL b2b_first: at=%0d c=%b sum=%0h, required at=%0d c=0 sum=10", d_at[0], c[0], s[0], W);
      end
      n_tests++;
      if (d_at[1] - d_at[0] !== W + 2 || {c[1], s[1]} !== {1'b1, W'(8'h00)}) begin
         n_fail++;
         $display("FAIL b2b_second: gap=%0d c=%b sum=%0h, required gap=%0d c=1 sum=0",
                  d_at[1] - d_at[0], c[1], s[1], W + 2);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, s;
      logic c;
      logic [W:0] exp_r;
      int lat, bn;
      for (int k = 0; k < 16; k++) begin
         x = W'($urandom);
         y = W'($urandom);
         do_op(x, y, s, c, lat, bn);
         exp_r = model(x, y, 1'b0);
         n_tests++;
         if ({c, s} !== exp_r || lat !== W) begin
            n_fail++;
            $display("FAIL random_add %0d+%0d: got c=%b sum=%0d lat=%0d, required c=%b sum=%0d lat=%0d",
                     x, y, c, s, lat, exp_r[W], exp_r[W-1:0], W);
         end
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      logic [W-1:0] xs [3];
      logic [W-1:0] ys [3];
      logic         ss [3];
      logic [W-1:0] x, y, s;
      logic c, m;
      logic [W:0] exp_r;
      int lat, bn;
      xs[0] = W'(5); ys[0] = W'(3); ss[0] = 1'b1;
      xs[1] = W'(3); ys[1] = W'(5); ss[1] = 1'b1;
      xs[2] = W'(3); ys[2] = W'(5); ss[2] = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (k < 3) begin
            x = xs[k]; y = ys[k]; m = ss[k];
         end else begin
            x = W'($urandom); y = W'($urandom); m = 1'($urandom);
         end
         bus.sub = m;
         do_op(x, y, s, c, lat, bn);
         exp_r = model(x, y, m);
         n_tests++;
         if ({c, s} !== exp_r) begin
            n_fail++;
            $display("FAIL sub_mode sub=%b a=%0d b=%0d: got c=%b sum=%0d, required c=%b sum=%0d",
                     m, x, y, c, s, exp_r[W], exp_r[W-1:0]);
         end
      end
      bus.sub = 1'b0;
   endtask
`endif

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = 1'b0;
`endif
      test_reset();
      test_basic();
      test_overflow();
      test_start_ignored();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
